// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: AHB transfer-type encodings and the bridge FSM state type.
package ahb2apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } bridge_state_e;

    // Only NONSEQ/SEQ carry a real beat; IDLE/BUSY get a zero-wait OKAY.
    function automatic logic is_xfer(input logic [1:0] t);
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB master, one beat outstanding, word-only.
// Build option APB_PSLVERR_EN adds the pslverr port and the two-cycle AHB ERROR response.
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready_in,
    output logic          hreadyout,
    output logic [DW-1:0] hrdata,
    output logic          hresp,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    output logic          psel,
    output logic          penable,
    input  logic [DW-1:0] prdata,
`ifdef APB_PSLVERR_EN
    input  logic          pslverr,
`endif
    input  logic          pready
);

    bridge_state_e state;
    logic          accept;

    assign accept = hsel && hready_in && is_xfer(htrans);

`ifndef APB_PSLVERR_EN
    assign hresp = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hrdata    <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
`ifdef APB_PSLVERR_EN
            hresp     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    paddr     <= haddr;
                    pwrite    <= hwrite;
                    hreadyout <= 1'b0;
                    // Writes need one cycle to pick up hwdata from the AHB data phase.
                    if (hwrite) begin
                        state <= WDATA;
                    end else begin
                        psel  <= 1'b1;
                        state <= SETUP;
                    end
                end
                WDATA: begin
                    pwdata <= hwdata;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: if (pready) begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
`ifdef APB_PSLVERR_EN
                    if (pslverr) begin
                        hresp <= 1'b1;
                        state <= ERR1;
                    end else
`endif
                    begin
                        if (!pwrite) hrdata <= prdata;
                        hreadyout <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef APB_PSLVERR_EN
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
